seg_phase_divider: RTL and testbench

SEG_PHASE_DIVIDER -- requirements
Module: seg_phase_divider

---
 rtl/seg_phase_divider_if.sv | 18 +
 rtl/seg_phase_divider.sv | 138 +++++++++++++
 tb/tb_seg_phase_divider.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seg_phase_divider_if.sv
// Control and status bundle for seg_phase_divider: run requests and shared settings in,
// per-channel divided output, busy and done status out.
interface seg_phase_divider_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 26,
  parameter int PH_W     = 8
);
  logic [CHANNELS-1:0] start;
  logic [CNT_W-1:0]    period;
  logic                mode;
  logic [PH_W-1:0]     phase_limit;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] done;

  modport master (output start, period, mode, phase_limit, input out, busy, done);
  modport slave  (input start, period, mode, phase_limit, output out, busy, done);
endinterface

// File: rtl/seg_phase_divider.sv
// Multi-channel clock divider: each channel ticks every max(period,1) cycles while its start is
// held, producing a toggle or single-cycle pulse output and an optional tick-limited run.
module seg_phase_divider #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 26,
  parameter int PH_W     = 8
) (
  input  logic                clock,
  input  logic                rstn,
  seg_phase_divider_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  logic [CHANNELS-1:0] out_v;
  logic [CHANNELS-1:0] busy_v;
  logic [CHANNELS-1:0] done_v;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_ch
      state_t            state_r, state_nx;
      logic [CNT_W-1:0]  cnt_r, cnt_nx, pe_r, pe_nx;
      logic [PH_W-1:0]   ph_r, ph_nx, lim_r, lim_nx;
      logic              mode_r, mode_nx;
      logic              out_r, out_nx, busy_r, busy_nx, done_r, done_nx;
      logic              tick_s, last_s;

      // Next-state and next-output logic for one channel
      always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        ph_nx    = ph_r;
        pe_nx    = pe_r;
        lim_nx   = lim_r;
        mode_nx  = mode_r;
        out_nx   = out_r;
        busy_nx  = busy_r;
        done_nx  = 1'b0;
        tick_s   = (cnt_r == CNT_W'(1));
        // Limit of zero never matches, so a free-running ph just wraps
        last_s   = (lim_r != PH_W'(0)) && ((ph_r + PH_W'(1)) == lim_r);
        case (state_r)
          IDLE: begin
            cnt_nx  = CNT_W'(0);
            ph_nx   = PH_W'(0);
            out_nx  = 1'b0;
            busy_nx = 1'b0;
            if (bus.start[g]) begin
              state_nx = RUN;
              cnt_nx   = CNT_W'(1);
              pe_nx    = (bus.period == CNT_W'(0)) ? CNT_W'(1) : bus.period;
              lim_nx   = bus.phase_limit;
              mode_nx  = bus.mode;
              busy_nx  = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
          RUN: begin
            if (!bus.start[g]) begin
              state_nx = IDLE;
              cnt_nx   = CNT_W'(0);
              ph_nx    = PH_W'(0);
              out_nx   = 1'b0;
              busy_nx  = 1'b0;
            end else begin
              cnt_nx = (cnt_r == pe_r) ? CNT_W'(1) : (cnt_r + CNT_W'(1));
              if (tick_s) begin
                ph_nx  = ph_r + PH_W'(1);
                out_nx = mode_r ? 1'b1 : ~out_r;
                if (last_s) begin
                  state_nx = DONE;
                  done_nx  = 1'b1;
                  busy_nx  = 1'b0;
                end else begin
                  state_nx = RUN;
                end
              end else begin
                out_nx = mode_r ? 1'b0 : out_r;
              end
            end
          end
          DONE: begin
            out_nx = mode_r ? 1'b0 : out_r;
            if (!bus.start[g]) begin
              state_nx = IDLE;
              cnt_nx   = CNT_W'(0);
              ph_nx    = PH_W'(0);
              out_nx   = 1'b0;
            end else begin
              state_nx = DONE;
            end
          end
          default: begin
            state_nx = IDLE;
            cnt_nx   = CNT_W'(0);
            ph_nx    = PH_W'(0);
            out_nx   = 1'b0;
            busy_nx  = 1'b0;
          end
        endcase
      end

      // Channel state register with synchronous active-low reset
      always_ff @(posedge clock) begin
        if (!rstn) begin
          state_r <= IDLE;
          cnt_r   <= CNT_W'(0);
          ph_r    <= PH_W'(0);
          pe_r    <= CNT_W'(1);
          lim_r   <= PH_W'(0);
          mode_r  <= 1'b0;
          out_r   <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end else begin
          state_r <= state_nx;
          cnt_r   <= cnt_nx;
          ph_r    <= ph_nx;
          pe_r    <= pe_nx;
          lim_r   <= lim_nx;
          mode_r  <= mode_nx;
          out_r   <= out_nx;
          busy_r  <= busy_nx;
          done_r  <= done_nx;
        end
      end

      assign out_v[g]  = out_r;
      assign busy_v[g] = busy_r;
      assign done_v[g] = done_r;
    end
  endgenerate

  assign bus.out  = out_v;
  assign bus.busy = busy_v;
  assign bus.done = done_v;
endmodule

// File: tb/tb_seg_phase_divider.sv
// Directed bench for seg_phase_divider: a vector table for limited toggle/pulse runs plus
// hand-written sequences for free-running timing, abort, reset, short periods and channel offset.
module tb_seg_phase_divider;
  logic clock = 1'b0;
  logic rstn  = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  seg_phase_divider_if #(.CHANNELS(4), .CNT_W(26), .PH_W(8)) bus ();

  seg_phase_divider #(.CHANNELS(4), .CNT_W(26), .PH_W(8)) dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  st;
    logic [25:0] per;
    logic        md;
    logic [7:0]  lim;
    logic [3:0]  eo;
    logic [3:0]  eb;
    logic [3:0]  ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] st, input logic [25:0] per, input logic md,
                             input logic [7:0] lim, input logic [3:0] eo, input logic [3:0] eb,
                             input logic [3:0] ed);
    vec_t r;
    r.st = st; r.per = per; r.md = md; r.lim = lim; r.eo = eo; r.eb = eb; r.ed = ed;
    return r;
  endfunction

  // Expected toggle-mode output i edges after RUN entry (entry edge is i = 0)
  function automatic logic exp_tog(input int i, input int p);
    if (i < 1) return 1'b0;
    return logic'((((i - 1) / p) + 1) % 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [25:0] per, input logic md,
                       input logic [7:0] lim);
    bus.start = st; bus.period = per; bus.mode = md; bus.phase_limit = lim;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " out"},  32'(bus.out),  32'd0);
    chk({nm, " busy"}, 32'(bus.busy), 32'd0);
    chk({nm, " done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    // Limited toggle run on ch0: period 4, limit 3; settings altered mid-run must be ignored
    tbl.push_back(v(4'b0000, 26'd4, 1'b0, 8'd3, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd4, 1'b0, 8'd3, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0000, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0000, 4'b0001));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0001, 26'd7, 1'b1, 8'd1, 4'b0001, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 26'd7, 1'b1, 8'd1, 4'b0000, 4'b0000, 4'b0000));
    // Free-running pulse run on ch1: period 3
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0010, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0010, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0010, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0010, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0010, 4'b0000));
    tbl.push_back(v(4'b0000, 26'd3, 1'b1, 8'd0, 4'b0000, 4'b0000, 4'b0000));
    // Limited pulse run on ch3: period 2, limit 2
    tbl.push_back(v(4'b1000, 26'd2, 1'b1, 8'd2, 4'b0000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 26'd2, 1'b1, 8'd2, 4'b1000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 26'd2, 1'b1, 8'd2, 4'b0000, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1000, 26'd2, 1'b1, 8'd2, 4'b1000, 4'b0000, 4'b1000));
    tbl.push_back(v(4'b1000, 26'd2, 1'b1, 8'd2, 4'b0000, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 26'd2, 1'b1, 8'd2, 4'b0000, 4'b0000, 4'b0000));

    bus.start = 4'b0000; bus.period = 26'd0; bus.mode = 1'b0; bus.phase_limit = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    chk_all_zero("reset");
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].per, tbl[i].md, tbl[i].lim);
      chk($sformatf("tbl%0d out", i),  32'(bus.out),  32'(tbl[i].eo));
      chk($sformatf("tbl%0d busy", i), 32'(bus.busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d done", i), 32'(bus.done), 32'(tbl[i].ed));
    end

    // Free-running toggle on ch0, period 4
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk("free entry busy", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 13; i++) begin
      drive(4'b0001, 26'd4, 1'b0, 8'd0);
      chk($sformatf("free out i%0d", i), 32'(bus.out[0]), 32'(exp_tog(i, 4)));
      chk($sformatf("free done i%0d", i), 32'(bus.done), 32'd0);
    end
    drive(4'b0000, 26'd4, 1'b0, 8'd0);
    chk_all_zero("free stop");

    // Abort mid-run, then restart: first tick right after re-entry
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk("abort pre out", 32'(bus.out[0]), 32'd1);
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    drive(4'b0000, 26'd4, 1'b0, 8'd0);
    chk_all_zero("abort");
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk("restart busy", 32'(bus.busy), 32'd1);
    chk("restart out0", 32'(bus.out), 32'd0);
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk("restart tick", 32'(bus.out), 32'd1);
    drive(4'b0000, 26'd4, 1'b0, 8'd0);

    // Reset mid-run with start held; RUN re-entered on first edge out of reset
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    rstn = 1'b0;
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk_all_zero("midrun reset");
    rstn = 1'b1;
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk("post reset busy", 32'(bus.busy), 32'd1);
    chk("post reset out", 32'(bus.out), 32'd0);
    drive(4'b0001, 26'd4, 1'b0, 8'd0);
    chk("post reset tick", 32'(bus.out), 32'd1);
    drive(4'b0000, 26'd4, 1'b0, 8'd0);

    // period 0 and 1 both tick every cycle
    for (int p = 0; p < 2; p++) begin
      drive(4'b0001, 26'(p), 1'b0, 8'd0);
      for (int i = 1; i <= 4; i++) begin
        drive(4'b0001, 26'(p), 1'b0, 8'd0);
        chk($sformatf("per%0d out i%0d", p, i), 32'(bus.out[0]), 32'(exp_tog(i, 1)));
      end
      drive(4'b0000, 26'(p), 1'b0, 8'd0);
    end

    // ch0 and ch2 started two cycles apart stay two cycles offset
    for (int t = 0; t <= 14; t++) begin
      drive((t >= 2) ? 4'b0101 : 4'b0001, 26'd4, 1'b0, 8'd0);
      chk($sformatf("offset ch0 t%0d", t), 32'(bus.out[0]), 32'(exp_tog(t, 4)));
      chk($sformatf("offset ch2 t%0d", t), 32'(bus.out[2]), 32'(exp_tog(t - 2, 4)));
    end
    drive(4'b0000, 26'd4, 1'b0, 8'd0);
    chk_all_zero("final idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
